// File: rtl/local_inject_arbiter_pkg.sv
// Shared router link constants used by the local injection path.
package local_inject_arbiter_pkg;

    localparam int unsigned ROUTER_WIDTH = 32;
    localparam int unsigned DIR_LOCAL    = 4;

endpackage

// File: rtl/local_inject_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: searches ptr+1 .. ptr (mod N), one-hot grant.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant
);

    localparam int unsigned PW = $clog2(N);

    logic          found;
    logic [PW-1:0] idx;
    int unsigned   pos;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        pos   = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            pos = int'(ptr) + k;
            idx = PW'(pos % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/local_inject_arbiter.sv
// Credit-based round-robin injector into a router LOCAL input port.
// Define INJ_CREDIT_CHECK_EN for a sticky credit-overflow flag and saturating count.
module local_inject_arbiter
    import local_inject_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned CREDIT_DEPTH = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ*ROUTER_WIDTH-1:0]      req_data,
    output logic [NUM_REQ-1:0]                   req_ready,
    output logic                                 inj_data_valid,
    output logic [ROUTER_WIDTH-1:0]              inj_data,
    input  logic                                 inj_credit,
    output logic [$clog2(CREDIT_DEPTH+1)-1:0]    credit_count,
    output logic                                 idle,
    output logic                                 credit_err
);

    localparam int unsigned PW = $clog2(NUM_REQ);
    localparam int unsigned CW = $clog2(CREDIT_DEPTH + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(CREDIT_DEPTH);

    logic [CW-1:0]           cnt_q, cnt_d;
    logic [PW-1:0]           ptr_q, gidx;
    logic                    valid_q;
    logic [ROUTER_WIDTH-1:0] data_q, sel_data;
    logic [NUM_REQ-1:0]      arb_grant;
    logic                    consume;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (arb_grant)
    );

    // No same-cycle credit bypass: only credits already held can be spent.
    assign req_ready = (!rst && cnt_q != '0) ? arb_grant : '0;
    assign consume   = |req_ready;

    always_comb begin
        sel_data = '0;
        gidx     = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                sel_data = req_data[i*ROUTER_WIDTH +: ROUTER_WIDTH];
                gidx     = PW'(i);
            end
        end
    end

`ifdef INJ_CREDIT_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        cnt_d = cnt_q - CW'(consume) + CW'(inj_credit);
        err_d = err_q;
        if (inj_credit && !consume && cnt_q == CNT_MAX) begin
            err_d = 1'b1;
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign credit_err = err_q;
`else
    always_comb begin
        cnt_d = cnt_q - CW'(consume) + CW'(inj_credit);
    end

    assign credit_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= CNT_MAX;
            ptr_q   <= PW'(NUM_REQ - 1);
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            valid_q <= consume;
            if (consume) begin
                ptr_q  <= gidx;
                data_q <= sel_data;
            end
        end
    end

    assign inj_data_valid = valid_q;
    assign inj_data       = data_q;
    assign credit_count   = cnt_q;
    assign idle           = (cnt_q == CNT_MAX) && !valid_q;

endmodule

// File: tb/tb_local_inject_arbiter.sv
// Directed bench for local_inject_arbiter (NUM_REQ=4, CREDIT_DEPTH=2).
module tb_local_inject_arbiter;
    import local_inject_arbiter_pkg::*;

    localparam int unsigned NR = 4;
    localparam int unsigned CD = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NR-1:0]            req_valid;
    logic [NR*ROUTER_WIDTH-1:0] req_data;
    logic [NR-1:0]            req_ready;
    logic                     inj_data_valid;
    logic [ROUTER_WIDTH-1:0]  inj_data;
    logic                     inj_credit;
    logic [1:0]               credit_count;
    logic                     idle;
    logic                     credit_err;

    int vectors    = 0;
    int miscompares = 0;

    local_inject_arbiter #(.NUM_REQ(NR), .CREDIT_DEPTH(CD)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .inj_data_valid (inj_data_valid),
        .inj_data       (inj_data),
        .inj_credit     (inj_credit),
        .credit_count   (credit_count),
        .idle           (idle),
        .credit_err     (credit_err)
    );

    always #5 clk = ~clk;

    function automatic logic [ROUTER_WIDTH-1:0] cdata(input int unsigned i);
        return 32'hA5A0_0000 + 32'(i * 32'h111);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        req_valid  = '0;
        inj_credit = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        vectors++;
        if (credit_count !== 2'd2) begin miscompares++; $display("FAIL reset_count got %0d exp 2", credit_count); end
        vectors++;
        if (idle !== 1'b1) begin miscompares++; $display("FAIL reset_idle got %b exp 1", idle); end
        vectors++;
        if (inj_data_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b exp 0", inj_data_valid); end
        vectors++;
        if (inj_data !== '0) begin miscompares++; $display("FAIL reset_data got %h exp 0", inj_data); end
        vectors++;
        if (credit_err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b exp 0", credit_err); end
        rst       = 1'b1;
        req_valid = 4'b1111;
        #1;
        vectors++;
        if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL ready_in_reset got %b exp 0000", req_ready); end
        req_valid = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] exp_rdy [7] = '{4'b0001, 4'b0010, 4'b0000, 4'b0100, 4'b1000, 4'b0000, 4'b0001};
        logic          exp_v   [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [1:0]    exp_cnt [7] = '{2'd2, 2'd1, 2'd0, 2'd1, 2'd1, 2'd0, 2'd1};
        logic          crd     [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        int unsigned   exp_cl  [7] = '{0, 0, 1, 1, 2, 3, 3};
        do_reset();
        req_valid = 4'b1111;
        for (int c = 0; c < 7; c++) begin
            inj_credit = crd[c];
            #1;
            vectors++;
            if (req_ready !== exp_rdy[c]) begin miscompares++; $display("FAIL rr_ready cyc %0d got %b exp %b", c, req_ready, exp_rdy[c]); end
            vectors++;
            if (inj_data_valid !== exp_v[c]) begin miscompares++; $display("FAIL rr_valid cyc %0d got %b exp %b", c, inj_data_valid, exp_v[c]); end
            vectors++;
            if (credit_count !== exp_cnt[c]) begin miscompares++; $display("FAIL rr_count cyc %0d got %0d exp %0d", c, credit_count, exp_cnt[c]); end
            if (c > 0) begin
                vectors++;
                if (inj_data !== cdata(exp_cl[c])) begin miscompares++; $display("FAIL rr_data cyc %0d got %h exp %h", c, inj_data, cdata(exp_cl[c])); end
            end
            tick();
        end
        req_valid  = '0;
        inj_credit = 1'b0;
    endtask

    task automatic test_credit_exhaustion();
        logic [NR-1:0] exp_rdy [7] = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000};
        logic [1:0]    exp_cnt [7] = '{2'd2, 2'd1, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0};
        logic          crd     [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        do_reset();
        req_valid = 4'b1111;
        for (int c = 0; c < 7; c++) begin
            inj_credit = crd[c];
            #1;
            vectors++;
            if (req_ready !== exp_rdy[c]) begin miscompares++; $display("FAIL exh_ready cyc %0d got %b exp %b", c, req_ready, exp_rdy[c]); end
            vectors++;
            if (credit_count !== exp_cnt[c]) begin miscompares++; $display("FAIL exh_count cyc %0d got %0d exp %0d", c, credit_count, exp_cnt[c]); end
            if (c == 1) begin
                vectors++;
                if (idle !== 1'b0) begin miscompares++; $display("FAIL exh_idle got %b exp 0", idle); end
            end
            tick();
        end
        req_valid  = '0;
        inj_credit = 1'b0;
    endtask

    task automatic test_simultaneous();
        logic [NR-1:0] rv      [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b0000};
        logic          crd     [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [NR-1:0] exp_rdy [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b0000};
        logic [1:0]    exp_cnt [4] = '{2'd2, 2'd2, 2'd1, 2'd1};
        do_reset();
        for (int c = 0; c < 4; c++) begin
            req_valid  = rv[c];
            inj_credit = crd[c];
            #1;
            vectors++;
            if (req_ready !== exp_rdy[c]) begin miscompares++; $display("FAIL sim_ready cyc %0d got %b exp %b", c, req_ready, exp_rdy[c]); end
            vectors++;
            if (credit_count !== exp_cnt[c]) begin miscompares++; $display("FAIL sim_count cyc %0d got %0d exp %0d", c, credit_count, exp_cnt[c]); end
            vectors++;
            if (credit_err !== 1'b0) begin miscompares++; $display("FAIL sim_err cyc %0d got %b exp 0", c, credit_err); end
            tick();
        end
        req_valid  = '0;
        inj_credit = 1'b0;
    endtask

    task automatic test_overflow();
        do_reset();
        inj_credit = 1'b1;
        tick();
        inj_credit = 1'b0;
`ifdef INJ_CREDIT_CHECK_EN
        vectors++;
        if (credit_err !== 1'b1) begin miscompares++; $display("FAIL ovf_err got %b exp 1", credit_err); end
        vectors++;
        if (credit_count !== 2'd2) begin miscompares++; $display("FAIL ovf_count got %0d exp 2", credit_count); end
        tick();
        vectors++;
        if (credit_err !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky got %b exp 1", credit_err); end
`else
        vectors++;
        if (credit_err !== 1'b0) begin miscompares++; $display("FAIL ovf_err_off got %b exp 0", credit_err); end
        tick();
        vectors++;
        if (credit_err !== 1'b0) begin miscompares++; $display("FAIL ovf_err_off2 got %b exp 0", credit_err); end
`endif
        do_reset();
        vectors++;
        if (credit_err !== 1'b0) begin miscompares++; $display("FAIL ovf_clear got %b exp 0", credit_err); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_valid = 4'b1111;
        tick();
        tick();
        #1;
        vectors++;
        if (credit_count !== 2'd0 || inj_data_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_pre got cnt %0d v %b exp cnt 0 v 1", credit_count, inj_data_valid);
        end
        rst = 1'b1;
        tick();
        vectors++;
        if (inj_data_valid !== 1'b0) begin miscompares++; $display("FAIL mid_valid got %b exp 0", inj_data_valid); end
        vectors++;
        if (credit_count !== 2'd2) begin miscompares++; $display("FAIL mid_count got %0d exp 2", credit_count); end
        vectors++;
        if (inj_data !== '0) begin miscompares++; $display("FAIL mid_data got %h exp 0", inj_data); end
        vectors++;
        if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL mid_ready_rst got %b exp 0000", req_ready); end
        rst = 1'b0;
        #1;
        vectors++;
        if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL mid_first_grant got %b exp 0001", req_ready); end
        tick();
        vectors++;
        if (inj_data_valid !== 1'b1 || inj_data !== cdata(0)) begin
            miscompares++;
            $display("FAIL mid_first_data got v %b d %h exp v 1 d %h", inj_data_valid, inj_data, cdata(0));
        end
        req_valid = '0;
    endtask

    initial begin
        for (int i = 0; i < int'(NR); i++) req_data[i*ROUTER_WIDTH +: ROUTER_WIDTH] = cdata(i);
        rst        = 1'b1;
        req_valid  = '0;
        inj_credit = 1'b0;
        test_reset();
        test_round_robin();
        test_credit_exhaustion();
        test_simultaneous();
        test_overflow();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule
